// File: rtl/instr_encoder_if.sv
// Field-set in, {addr, word} out stream bundle for the RV32I instruction encoder.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carried alongside their valid strobes.
interface instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_func3;
    logic              in_f7;
    logic [31:0]       in_imm;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic              err_range;
    logic              err_clear;
    logic [15:0]       count;

    // Producer of field sets / consumer of encoded words (test or boot logic).
    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_f7, in_imm,
        output base_load, base_addr, out_ready, err_clear,
        input  in_ready, out_valid, out_instr, out_addr, err_illegal, err_range, count
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_f7, in_imm,
        input  base_load, base_addr, out_ready, err_clear,
        output in_ready, out_valid, out_instr, out_addr, err_illegal, err_range, count
    );
endinterface

// File: rtl/instr_encoder.sv
// Small synchronous FIFO holding {addr, word} entries for the encoder output.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full/empty from registered occupancy; caller never pushes when full.
module enc_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occ;

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (!push && pop) occ <= occ - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign full     = (occ == (PW+1)'(DEPTH));
    assign empty    = (occ == '0);
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

// RV32I encoder: range-checks decoded fields, packs them into a word tagged with an auto-incrementing address.
// Latency: accepted word reaches the output head one cycle later when the FIFO was empty.
// Backpressure: in_ready = !full (registered state only, independent of out_ready); illegal/out-of-range sets are consumed and dropped.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    instr_encoder_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0]       imm;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic              fits12;
    logic              fits13;
    logic              fits21;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              enc_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] base_aligned;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] addr_ctr;
    logic [15:0]       cnt;
    logic              err_ill_q;
    logic              err_rng_q;
    logic [ADDR_W+31:0] head_dat;
    logic [1:0]        unused_base_lsbs;

    assign imm = bus.in_imm;
    assign op  = bus.in_opcode;
    assign f3  = bus.in_func3;

    // Signed-fit tests: the value is representable when all bits above the field's sign bit match it.
    assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

    // Format selection, range check and bit packing for the presented field set.
    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        enc_range   = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                enc_range = (imm[11:0] != '0);
                enc_word  = {imm[31:12], bus.in_rd, op};
            end
            OP_JAL: begin
                enc_range = !fits21 || imm[0];
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, op};
            end
            OP_JALR, OP_LOAD: begin
                enc_range = !fits12;
                enc_word  = {imm[11:0], bus.in_rs1, f3, bus.in_rd, op};
            end
            OP_OPIMM: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shifts carry a 5-bit shamt; only SRAI takes instr[30] from f7.
                    enc_range = (imm[31:5] != '0);
                    enc_word  = {1'b0, (f3 == 3'b101) && bus.in_f7, 5'b0, imm[4:0],
                                 bus.in_rs1, f3, bus.in_rd, op};
                end else begin
                    enc_range = !fits12;
                    enc_word  = {imm[11:0], bus.in_rs1, f3, bus.in_rd, op};
                end
            end
            OP_STORE: begin
                enc_range = !fits12;
                enc_word  = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], op};
            end
            OP_BRANCH: begin
                enc_range = !fits13 || imm[0];
                enc_word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                             imm[4:1], imm[11], op};
            end
            OP_OP: begin
                enc_word = {1'b0, bus.in_f7, 5'b0, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, op};
            end
            default: begin
                enc_illegal = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !enc_illegal && !enc_range;
    assign pop    = bus.out_valid && bus.out_ready;

    // A same-cycle base_load retargets the entry being pushed, so the tag comes from the new base.
    assign base_aligned     = {bus.base_addr[ADDR_W-1:2], 2'b00};
    assign push_addr        = bus.base_load ? base_aligned : addr_ctr;
    assign unused_base_lsbs = bus.base_addr[1:0];

    // Address counter and push count; base_load restarts both.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_ctr <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                addr_ctr <= push_addr + ADDR_W'(4);
                cnt      <= bus.base_load ? 16'd1 : cnt + 16'd1;
            end else if (bus.base_load) begin
                addr_ctr <= base_aligned;
                cnt      <= '0;
            end
        end
    end

    // Sticky error flags; a clear wins over a set arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else if (bus.err_clear) begin
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else if (accept) begin
            if (enc_illegal) err_ill_q <= 1'b1;
            if (enc_range)   err_rng_q <= 1'b1;
        end
    end

    enc_fifo #(
        .W     (ADDR_W + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({push_addr, enc_word}),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_dat)
    );

    assign bus.in_ready    = !fifo_full;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_instr   = head_dat[31:0];
    assign bus.out_addr    = head_dat[ADDR_W+31:32];
    assign bus.err_illegal = err_ill_q;
    assign bus.err_range   = err_rng_q;
    assign bus.count       = cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic scored against an arithmetic reference model with a queue FIFO.
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic        push;
        logic [31:0] word;
        logic        ill;
        logic        rng;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one field set and hold it until it is accepted.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
        int n;
        bus.in_opcode = op;  bus.in_rd  = rd;  bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_func3  = f3;  bus.in_f7  = f7;  bus.in_imm = imm;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("send_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid  = 1'b0;
        bus.base_load = 1'b0;
        bus.err_clear = 1'b0;
    endtask

    // Reference encoder: range rules as signed arithmetic, fields placed by shift/mask.
    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] m;
        m = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (v >> lo) & m;
    endfunction

    // Returns 0 = encodable, 1 = illegal opcode, 2 = immediate out of range.
    function automatic int model_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] imm, output logic [31:0] w);
        int s;
        int kind;
        logic [31:0] o, d, a, b, f;
        s = $signed(imm);
        o = 32'(op); d = 32'(rd) << 7; a = 32'(rs1) << 15; b = 32'(rs2) << 20; f = 32'(f3) << 12;
        w = '0;
        kind = 0;
        case (op)
            7'h37, 7'h17: begin
                if (s % 4096 != 0) kind = 2;
                else w = (imm & 32'hFFFF_F000) | d | o;
            end
            7'h6F: begin
                if (s < -(1 << 20) || s > (1 << 20) - 2 || s % 2 != 0) kind = 2;
                else w = (fld(imm,20,20) << 31) | (fld(imm,10,1) << 21) | (fld(imm,11,11) << 20)
                       | (fld(imm,19,12) << 12) | d | o;
            end
            7'h67, 7'h03: begin
                if (s < -2048 || s > 2047) kind = 2;
                else w = (fld(imm,11,0) << 20) | a | f | d | o;
            end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (s < 0 || s > 31) kind = 2;
                    else w = ((f3 == 3'd5 && f7) ? 32'h4000_0000 : 32'h0) | (fld(imm,4,0) << 20) | a | f | d | o;
                end else begin
                    if (s < -2048 || s > 2047) kind = 2;
                    else w = (fld(imm,11,0) << 20) | a | f | d | o;
                end
            end
            7'h23: begin
                if (s < -2048 || s > 2047) kind = 2;
                else w = (fld(imm,11,5) << 25) | b | a | f | (fld(imm,4,0) << 7) | o;
            end
            7'h63: begin
                if (s < -4096 || s > 4094 || s % 2 != 0) kind = 2;
                else w = (fld(imm,12,12) << 31) | (fld(imm,10,5) << 25) | b | a | f
                       | (fld(imm,4,1) << 8) | (fld(imm,11,11) << 7) | o;
            end
            7'h33: w = (f7 ? 32'h4000_0000 : 32'h0) | b | a | f | d | o;
            default: kind = 1;
        endcase
        return kind;
    endfunction

    logic [63:0] mq [$];
    logic [31:0] m_addr;
    logic [15:0] m_count;
    logic        m_ill, m_rng;
    logic [6:0]  op_pool [11];

    initial begin
        logic [31:0] exp_addr;
        logic [15:0] exp_count;
        logic [31:0] w;
        int kind;
        logic accept;

        vecs[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,          1'b1, 32'h00500093, 1'b0, 1'b0};
        vecs[1]  = '{7'h13, 5'd2, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3,          1'b1, 32'h4030D113, 1'b0, 1'b0};
        vecs[2]  = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd8,        1'b1, 32'hFE208CE3, 1'b0, 1'b0};
        vecs[3]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,   1'b1, 32'h123452B7, 1'b0, 1'b0};
        vecs[4]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3,          1'b0, 32'h0,        1'b0, 1'b1};
        vecs[5]  = '{7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0,          1'b0, 32'h0,        1'b1, 1'b0};
        vecs[6]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,       1'b0, 32'h0,        1'b0, 1'b1};
        vecs[7]  = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, -32'sd2048,     1'b1, 32'h80008093, 1'b0, 1'b0};
        vecs[8]  = '{7'h13, 5'd3, 5'd3, 5'd0, 3'd1, 1'b1, 32'd31,         1'b1, 32'h01F19193, 1'b0, 1'b0};
        vecs[9]  = '{7'h13, 5'd3, 5'd3, 5'd0, 3'd5, 1'b0, 32'd32,         1'b0, 32'h0,        1'b0, 1'b1};
        vecs[10] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,          1'b1, 32'h0020A423, 1'b0, 1'b0};
        vecs[11] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'hDEAD,       1'b1, 32'h402081B3, 1'b0, 1'b0};
        vecs[12] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345001,   1'b0, 32'h0,        1'b0, 1'b1};
        vecs[13] = '{7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF00000,   1'b1, 32'h8000006F, 1'b0, 1'b0};
        vecs[14] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096,       1'b0, 32'h0,        1'b0, 1'b1};
        vecs[15] = '{7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF000,  1'b1, 32'hFFFFF517, 1'b0, 1'b0};
        vecs[16] = '{7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 1'b0, 32'd4,          1'b1, 32'h004280E7, 1'b0, 1'b0};
        vecs[17] = '{7'h03, 5'd6, 5'd2, 5'd0, 3'd2, 1'b0, -32'sd4,        1'b1, 32'hFFC12303, 1'b0, 1'b0};
        vecs[18] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,       1'b1, 32'h001000EF, 1'b0, 1'b0};
        vecs[19] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00100000,   1'b0, 32'h0,        1'b0, 1'b1};

        op_pool = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h13, 7'h33, 7'h7F};

        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.in_func3 = '0;   bus.in_f7 = 1'b0;   bus.in_imm = '0; bus.base_load = 1'b0;
        bus.base_addr = '0;  bus.out_ready = 1'b1; bus.err_clear = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_count", bus.count, 16'd0);
        check("rst_err_illegal", bus.err_illegal, 1'b0);
        check("rst_err_range", bus.err_range, 1'b0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", bus.out_addr, 32'd0);

        // Vector table, sink always ready
        exp_addr = 0; exp_count = 0;
        for (int i = 0; i < 20; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
            if (vecs[i].push) begin
                exp_count++;
                check($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
                check($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].word);
                check($sformatf("vec%0d_addr", i), bus.out_addr, exp_addr);
                check($sformatf("vec%0d_count", i), bus.count, exp_count);
                exp_addr += 4;
            end else begin
                check($sformatf("vec%0d_dropped", i), bus.out_valid, 1'b0);
                check($sformatf("vec%0d_err_illegal", i), bus.err_illegal, vecs[i].ill);
                check($sformatf("vec%0d_err_range", i), bus.err_range, vecs[i].rng);
                check($sformatf("vec%0d_count_held", i), bus.count, exp_count);
                bus.err_clear = 1'b1;
                tick();
                bus.err_clear = 1'b0;
                check($sformatf("vec%0d_clr_illegal", i), bus.err_illegal, 1'b0);
                check($sformatf("vec%0d_clr_range", i), bus.err_range, 1'b0);
            end
        end
        tick();
        check("table_drained", bus.out_valid, 1'b0);

        // base_load together with a push: entry takes the new (aligned) base
        bus.base_load = 1'b1; bus.base_addr = 32'h0000_1003;
        send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
        check("base_instr", bus.out_instr, 32'h123452B7);
        check("base_addr", bus.out_addr, 32'h1000);
        check("base_count", bus.count, 16'd1);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        check("base_next_addr", bus.out_addr, 32'h1004);
        check("base_next_count", bus.count, 16'd2);

        // err_clear beats a same-cycle range error; errors alone are sticky
        bus.err_clear = 1'b1;
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        check("clr_prio_range", bus.err_range, 1'b0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
        check("sticky_range", bus.err_range, 1'b1);
        check("sticky_illegal", bus.err_illegal, 1'b1);
        check("sticky_count", bus.count, 16'd2);
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;

        // Backpressure: fill, hold 5th, release one beat, check order
        rst = 1'b1; tick(); rst = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
        check("full_in_ready", bus.in_ready, 1'b0);
        bus.in_opcode = 7'h13; bus.in_rd = 5'd1; bus.in_rs1 = 5'd0; bus.in_func3 = 3'd0;
        bus.in_imm = 32'd4; bus.in_valid = 1'b1;
        tick(); tick();
        check("held_in_ready", bus.in_ready, 1'b0);
        check("held_head_addr", bus.out_addr, 32'd0);
        check("held_head_instr", bus.out_instr, 32'h00000093);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop_frees_slot", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("fifth_in_full", bus.in_ready, 1'b0);
        check("fifth_count", bus.count, 16'd5);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain%0d_valid", k), bus.out_valid, 1'b1);
            check($sformatf("drain%0d_addr", k), bus.out_addr, 32'(4 * k));
            check($sformatf("drain%0d_instr", k), bus.out_instr, 32'h00000093 | (32'(k) << 20));
            tick();
        end
        check("drain_empty", bus.out_valid, 1'b0);

        // Reset mid-backpressure discards queued entries
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
        rst = 1'b1;
        tick();
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_count", bus.count, 16'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9);
        check("midrst_push_addr", bus.out_addr, 32'd0);
        check("midrst_push_valid", bus.out_valid, 1'b1);

        // Randomized traffic against the queue model
        rst = 1'b1; tick(); rst = 1'b0;
        mq.delete();
        m_addr = 0; m_count = 0; m_ill = 0; m_rng = 0;
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_opcode = op_pool[$urandom_range(0, 10)];
            bus.in_rd     = 5'($urandom); bus.in_rs1 = 5'($urandom); bus.in_rs2 = 5'($urandom);
            bus.in_func3  = 3'($urandom); bus.in_f7  = 1'($urandom);
            case ($urandom_range(0, 4))
                0: bus.in_imm = 32'($urandom_range(0, 8000)) - 32'd4000;
                1: bus.in_imm = 32'($urandom_range(0, 40));
                2: bus.in_imm = 32'($urandom) & 32'hFFFF_F000;
                3: bus.in_imm = 32'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000;
                default: bus.in_imm = $urandom;
            endcase
            bus.base_load = ($urandom_range(0, 29) == 0);
            bus.base_addr = $urandom;
            bus.err_clear = ($urandom_range(0, 19) == 0);

            check("rnd_in_ready", bus.in_ready, mq.size() < DEPTH);
            check("rnd_out_valid", bus.out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                check("rnd_out_instr", bus.out_instr, mq[0][31:0]);
                check("rnd_out_addr", bus.out_addr, mq[0][63:32]);
            end
            check("rnd_count", bus.count, m_count);
            check("rnd_err_illegal", bus.err_illegal, m_ill);
            check("rnd_err_range", bus.err_range, m_rng);

            accept = bus.in_valid && (mq.size() < DEPTH);
            kind = model_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_func3,
                             bus.in_f7, bus.in_imm, w);
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            if (accept && kind == 0) begin
                logic [31:0] tag;
                tag = bus.base_load ? (bus.base_addr & ~32'd3) : m_addr;
                mq.push_back({tag, w});
                m_addr  = tag + 32'd4;
                m_count = bus.base_load ? 16'd1 : m_count + 16'd1;
            end else if (bus.base_load) begin
                m_addr  = bus.base_addr & ~32'd3;
                m_count = 16'd0;
            end
            if (bus.err_clear) begin
                m_ill = 1'b0; m_rng = 1'b0;
            end else if (accept) begin
                if (kind == 1) m_ill = 1'b1;
                if (kind == 2) m_rng = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
